// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port (instruction/data) memory bus arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   localparam logic ARB_PORT_I = 1'b0;
   localparam logic ARB_PORT_D = 1'b1;

   // One-hot grant to port id; an empty grant maps to the instruction port.
   function automatic logic port_of(input logic [1:0] gnt);
      return gnt[1] ? ARB_PORT_D : ARB_PORT_I;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       en_i,
   output logic [1:0] gnt_o,
   output logic       next_o
);

   always_comb begin
      gnt_o  = req_i;
      next_o = last_i;
      if (req_i[ARB_PORT_I] && req_i[ARB_PORT_D]) begin
         gnt_o = (last_i == ARB_PORT_D) ? 2'b01 : 2'b10;
      end
      if (en_i && (gnt_o != 2'b00)) begin
         next_o = port_of(gnt_o);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one strobe/busy memory bus between the instruction and data ports, one request queued per port.
// Zero-wait bus: strobe at T, bus strobe at T+2, rdata valid and busy low at T+4; bus busy stalls indefinitely.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int   ADDR_W  = 32,
   parameter int   DATA_W  = 32,
   parameter logic FIRST_D = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     mem_i_addr,
   input  logic                  mem_i_rstrb,
   output logic [DATA_W-1:0]     mem_i_rdata,
   output logic                  mem_i_rbusy,
   input  logic [ADDR_W-1:0]     mem_d_addr,
   input  logic [DATA_W-1:0]     mem_d_wdata,
   input  logic [DATA_W/8-1:0]   mem_d_wmask,
   input  logic                  mem_d_rstrb,
   input  logic                  mem_d_wstrb,
   output logic [DATA_W-1:0]     mem_d_rdata,
   output logic                  mem_d_rbusy,
   output logic                  mem_d_wbusy,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W-1:0]     bus_wdata,
   output logic [DATA_W/8-1:0]   bus_wmask,
   output logic                  bus_rstrb,
   output logic                  bus_wstrb,
   input  logic [DATA_W-1:0]     bus_rdata,
   input  logic                  bus_rbusy,
   input  logic                  bus_wbusy
);

   localparam int MASK_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   logic                i_pend_q, i_pend_d;
   logic [ADDR_W-1:0]   i_addr_q, i_addr_d;
   logic                d_pend_q, d_pend_d;
   logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
   logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;
   logic [MASK_W-1:0]   d_wmask_q, d_wmask_d;
   logic                d_we_q, d_we_d;
   logic                gnt_port_q, gnt_port_d;
   logic                gnt_we_q, gnt_we_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [MASK_W-1:0]   bus_wmask_q, bus_wmask_d;
   logic                bus_rstrb_q, bus_rstrb_d;
   logic                bus_wstrb_q, bus_wstrb_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic [1:0]          req;
   logic [1:0]          gnt;
   logic                arb_en;
   logic                win_d;
   logic                xfer_done;

   assign req    = {d_pend_q, i_pend_q};
   assign arb_en = (state_q == ARB_IDLE) && (req != 2'b00);

   rr_arb2 u_rr_arb2 (
      .req_i  (req),
      .last_i (last_q),
      .en_i   (arb_en),
      .gnt_o  (gnt),
      .next_o (last_d)
   );

   always_comb begin
      state_d     = state_q;
      i_pend_d    = i_pend_q;
      i_addr_d    = i_addr_q;
      d_pend_d    = d_pend_q;
      d_addr_d    = d_addr_q;
      d_wdata_d   = d_wdata_q;
      d_wmask_d   = d_wmask_q;
      d_we_d      = d_we_q;
      gnt_port_d  = gnt_port_q;
      gnt_we_d    = gnt_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wmask_d = bus_wmask_q;
      bus_rstrb_d = 1'b0;
      bus_wstrb_d = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      win_d       = (port_of(gnt) == ARB_PORT_D);
      xfer_done   = 1'b0;

      // A strobe only lands when its port has nothing queued.
      if (!i_pend_q && mem_i_rstrb) begin
         i_pend_d = 1'b1;
         i_addr_d = mem_i_addr;
      end
      if (!d_pend_q && (mem_d_rstrb || mem_d_wstrb)) begin
         d_pend_d  = 1'b1;
         d_addr_d  = mem_d_addr;
         d_wdata_d = mem_d_wdata;
         d_wmask_d = mem_d_wmask;
         d_we_d    = mem_d_wstrb;
      end

      unique case (state_q)
         ARB_IDLE: begin
            if (arb_en) begin
               gnt_port_d  = port_of(gnt);
               gnt_we_d    = win_d && d_we_q;
               bus_addr_d  = win_d ? d_addr_q : i_addr_q;
               bus_wdata_d = win_d ? d_wdata_q : '0;
               bus_wmask_d = (win_d && d_we_q) ? d_wmask_q : '0;
               bus_rstrb_d = !(win_d && d_we_q);
               bus_wstrb_d = win_d && d_we_q;
               state_d     = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            xfer_done = gnt_we_q ? !bus_wbusy : !bus_rbusy;
            if (xfer_done) begin
               if (gnt_port_q == ARB_PORT_D) begin
                  d_pend_d = 1'b0;
                  if (!gnt_we_q) d_rdata_d = bus_rdata;
               end else begin
                  i_pend_d  = 1'b0;
                  i_rdata_d = bus_rdata;
               end
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         i_pend_q    <= 1'b0;
         i_addr_q    <= '0;
         d_pend_q    <= 1'b0;
         d_addr_q    <= '0;
         d_wdata_q   <= '0;
         d_wmask_q   <= '0;
         d_we_q      <= 1'b0;
         gnt_port_q  <= ARB_PORT_I;
         gnt_we_q    <= 1'b0;
         last_q      <= FIRST_D;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wmask_q <= '0;
         bus_rstrb_q <= 1'b0;
         bus_wstrb_q <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         i_pend_q    <= i_pend_d;
         i_addr_q    <= i_addr_d;
         d_pend_q    <= d_pend_d;
         d_addr_q    <= d_addr_d;
         d_wdata_q   <= d_wdata_d;
         d_wmask_q   <= d_wmask_d;
         d_we_q      <= d_we_d;
         gnt_port_q  <= gnt_port_d;
         gnt_we_q    <= gnt_we_d;
         last_q      <= last_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wmask_q <= bus_wmask_d;
         bus_rstrb_q <= bus_rstrb_d;
         bus_wstrb_q <= bus_wstrb_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_i_rdata = i_rdata_q;
   assign mem_i_rbusy = i_pend_q;
   assign mem_d_rdata = d_rdata_q;
   assign mem_d_rbusy = d_pend_q && !d_we_q;
   assign mem_d_wbusy = d_pend_q && d_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wmask   = bus_wmask_q;
   assign bus_rstrb   = bus_rstrb_q;
   assign bus_wstrb   = bus_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bus model with programmable wait states and an in-order bus transaction scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_i_addr;
   logic        mem_i_rstrb;
   logic [31:0] mem_i_rdata;
   logic        mem_i_rbusy;
   logic [31:0] mem_d_addr;
   logic [31:0] mem_d_wdata;
   logic [3:0]  mem_d_wmask;
   logic        mem_d_rstrb;
   logic        mem_d_wstrb;
   logic [31:0] mem_d_rdata;
   logic        mem_d_rbusy;
   logic        mem_d_wbusy;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_rstrb;
   logic        bus_wstrb;
   logic [31:0] bus_rdata;
   logic        bus_rbusy;
   logic        bus_wbusy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_D(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_i_addr  (mem_i_addr),
      .mem_i_rstrb (mem_i_rstrb),
      .mem_i_rdata (mem_i_rdata),
      .mem_i_rbusy (mem_i_rbusy),
      .mem_d_addr  (mem_d_addr),
      .mem_d_wdata (mem_d_wdata),
      .mem_d_wmask (mem_d_wmask),
      .mem_d_rstrb (mem_d_rstrb),
      .mem_d_wstrb (mem_d_wstrb),
      .mem_d_rdata (mem_d_rdata),
      .mem_d_rbusy (mem_d_rbusy),
      .mem_d_wbusy (mem_d_wbusy),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_wmask   (bus_wmask),
      .bus_rstrb   (bus_rstrb),
      .bus_wstrb   (bus_wstrb),
      .bus_rdata   (bus_rdata),
      .bus_rbusy   (bus_rbusy),
      .bus_wbusy   (bus_wbusy)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } txn_t;

   txn_t exp_q[$];
   txn_t mon_e;
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   n_txn    = 0;
   int   bus_wait = 0;
   int   busy_cnt = 0;
   logic bus_we_cur = 1'b0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic txn_t mk_txn(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wmask);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.wmask = wmask;
      return t;
   endfunction

   assign bus_rdata = mem_val(bus_addr);
   assign bus_rbusy = (busy_cnt > 0) && !bus_we_cur;
   assign bus_wbusy = (busy_cnt > 0) && bus_we_cur;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, wanted 0x%08h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Bus model and scoreboard: every strobe is matched in order against the expected queue.
   always @(negedge clk) begin
      if (bus_rstrb || bus_wstrb) begin
         n_txn++;
         check("bus_one_strobe", 32'(bus_rstrb & bus_wstrb), 32'd0);
         check("bus_txn_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("bus_we", 32'(bus_wstrb), 32'(mon_e.we));
            check("bus_addr", bus_addr, mon_e.addr);
            if (mon_e.we) begin
               check("bus_wdata", bus_wdata, mon_e.wdata);
               check("bus_wmask", 32'(bus_wmask), 32'(mon_e.wmask));
            end
         end
         bus_we_cur = bus_wstrb;
         busy_cnt   = bus_wait + 1;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      mem_i_addr = '0; mem_i_rstrb = 1'b0;
      mem_d_addr = '0; mem_d_wdata = '0; mem_d_wmask = '0;
      mem_d_rstrb = 1'b0; mem_d_wstrb = 1'b0;
      do_reset();

      // Reset state
      check("rst_i_rbusy", 32'(mem_i_rbusy), 32'd0);
      check("rst_d_rbusy", 32'(mem_d_rbusy), 32'd0);
      check("rst_d_wbusy", 32'(mem_d_wbusy), 32'd0);
      check("rst_i_rdata", mem_i_rdata, 32'd0);
      check("rst_d_rdata", mem_d_rdata, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_strb", 32'({bus_rstrb, bus_wstrb}), 32'd0);

      // Isolated instruction read, zero-wait bus
      bus_wait = 0;
      exp_q.push_back(mk_txn(1'b0, 32'h10, 32'h0, 4'h0));
      mem_i_addr = 32'h10; mem_i_rstrb = 1'b1;
      check("iso_busy_T", 32'(mem_i_rbusy), 32'd0);
      tick(); mem_i_rstrb = 1'b0;
      check("iso_busy_T1", 32'(mem_i_rbusy), 32'd1);
      tick();
      check("iso_rstrb_T2", 32'(bus_rstrb), 32'd1);
      check("iso_addr_T2", bus_addr, 32'h10);
      tick();
      check("iso_rstrb_T3", 32'(bus_rstrb), 32'd0);
      tick();
      check("iso_rdata_T4", mem_i_rdata, 32'hDEADBEEF);
      check("iso_busy_T4", 32'(mem_i_rbusy), 32'd0);

      // Data store with three wait states
      bus_wait = 3;
      exp_q.push_back(mk_txn(1'b1, 32'h104, 32'h11223344, 4'b0010));
      mem_d_addr = 32'h104; mem_d_wdata = 32'h11223344; mem_d_wmask = 4'b0010; mem_d_wstrb = 1'b1;
      tick(); mem_d_wstrb = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check("st_wbusy_hold", 32'(mem_d_wbusy), 32'd1);
         if (k == 4) check("st_addr_stable", bus_addr, 32'h104);
         tick();
      end
      check("st_wbusy_T7", 32'(mem_d_wbusy), 32'd0);
      check("st_rbusy", 32'(mem_d_rbusy), 32'd0);
      check("st_d_rdata", mem_d_rdata, 32'd0);

      // Simultaneous requests after reset: instruction first
      do_reset();
      bus_wait = 1;
      exp_q.push_back(mk_txn(1'b0, 32'h20, 32'h0, 4'h0));
      exp_q.push_back(mk_txn(1'b0, 32'h30, 32'h0, 4'h0));
      mem_i_addr = 32'h20; mem_i_rstrb = 1'b1;
      mem_d_addr = 32'h30; mem_d_rstrb = 1'b1;
      tick(); mem_i_rstrb = 1'b0; mem_d_rstrb = 1'b0;
      for (int k = 0; k < 40 && (mem_i_rbusy || mem_d_rbusy); k++) tick();
      check("sim_done", 32'({mem_i_rbusy, mem_d_rbusy}), 32'd0);
      check("sim_i_rdata", mem_i_rdata, mem_val(32'h20));
      check("sim_d_rdata", mem_d_rdata, mem_val(32'h30));

      // rstrb+wstrb together is a write; a strobe on the pending port is dropped
      bus_wait = 3;
      exp_q.push_back(mk_txn(1'b1, 32'h200, 32'hCAFEF00D, 4'hF));
      mem_d_addr = 32'h200; mem_d_wdata = 32'hCAFEF00D; mem_d_wmask = 4'hF;
      mem_d_rstrb = 1'b1; mem_d_wstrb = 1'b1;
      tick(); mem_d_rstrb = 1'b0; mem_d_wstrb = 1'b0;
      check("both_wbusy", 32'(mem_d_wbusy), 32'd1);
      check("both_rbusy", 32'(mem_d_rbusy), 32'd0);
      tick();
      mem_d_addr = 32'h300; mem_d_rstrb = 1'b1;
      tick(); mem_d_rstrb = 1'b0;
      for (int k = 0; k < 40 && mem_d_wbusy; k++) tick();
      check("dup_done", 32'(mem_d_wbusy), 32'd0);
      for (int k = 0; k < 6; k++) tick();
      check("dup_no_pend", 32'(mem_d_rbusy), 32'd0);
      check("dup_queue_empty", 32'(exp_q.size()), 32'd0);

      // Fairness: I held high, D issues 4 back-to-back loads
      do_reset();
      bus_wait = 0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(mk_txn(1'b0, 32'h50, 32'h0, 4'h0));
         exp_q.push_back(mk_txn(1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'h0));
      end
      exp_q.push_back(mk_txn(1'b0, 32'h50, 32'h0, 4'h0));
      mem_i_addr = 32'h50; mem_i_rstrb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem_d_addr = 32'h80 + 32'(4 * k); mem_d_rstrb = 1'b1;
         tick(); mem_d_rstrb = 1'b0;
         for (int w = 0; w < 40 && mem_d_rbusy; w++) tick();
         check("fair_d_done", 32'(mem_d_rbusy), 32'd0);
         check("fair_d_rdata", mem_d_rdata, mem_val(32'h80 + 32'(4 * k)));
      end
      mem_i_rstrb = 1'b0;
      for (int w = 0; w < 40 && mem_i_rbusy; w++) tick();
      check("fair_i_done", 32'(mem_i_rbusy), 32'd0);
      check("fair_i_rdata", mem_i_rdata, mem_val(32'h50));
      for (int k = 0; k < 4; k++) tick();
      check("fair_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset while the bus is still busy
      bus_wait = 6;
      exp_q.push_back(mk_txn(1'b0, 32'h40, 32'h0, 4'h0));
      mem_i_addr = 32'h40; mem_i_rstrb = 1'b1;
      tick(); mem_i_rstrb = 1'b0;
      tick(); tick(); tick();
      check("mid_i_busy", 32'(mem_i_rbusy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busies", 32'({mem_i_rbusy, mem_d_rbusy, mem_d_wbusy}), 32'd0);
      check("mid_rst_strobes", 32'({bus_rstrb, bus_wstrb}), 32'd0);
      check("mid_rst_i_rdata", mem_i_rdata, 32'd0);
      for (int k = 0; k < 10; k++) tick();
      check("mid_late_i_rdata", mem_i_rdata, 32'd0);
      check("mid_late_i_busy", 32'(mem_i_rbusy), 32'd0);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("bus_txn_total", 32'(n_txn), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory bus between the rv32i instruction port (read-only) and data port (read/write).
- Sits between the core and the single-ported RAM/bus.
- Each requester sees a busy/strobe protocol identical to the memory side. Requests are queued, one per port, and granted round-robin.
- Exactly one bus transaction is in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the mask width is DATA_W/8.
- FIRST_D, 1, the last-grant pointer value after reset. 1 means instruction wins the first tie.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_i_addr  in  ADDR_W  instruction read address
- mem_i_rstrb  in  1  instruction read strobe
- mem_i_rdata  out  DATA_W  instruction read data, registered
- mem_i_rbusy  out  1  instruction request pending
- mem_d_addr  in  ADDR_W  data address
- mem_d_wdata  in  DATA_W  store data
- mem_d_wmask  in  DATA_W/8  byte enables
- mem_d_rstrb  in  1  data read strobe
- mem_d_wstrb  in  1  data write strobe
- mem_d_rdata  out  DATA_W  load data, registered
- mem_d_rbusy  out  1  data read pending
- mem_d_wbusy  out  1  data write pending
- bus_addr  out  ADDR_W  bus address, registered
- bus_wdata  out  DATA_W  bus write data, registered
- bus_wmask  out  DATA_W/8  bus byte mask, registered
- bus_rstrb  out  1  bus read strobe, single-cycle pulse
- bus_wstrb  out  1  bus write strobe, single-cycle pulse
- bus_rdata  in  DATA_W  bus read data
- bus_rbusy  in  1  bus read in progress
- bus_wbusy  in  1  bus write in progress

Behaviour:
- Reset: state=IDLE; i_pend=d_pend=0; last-grant pointer=FIRST_D.
- Reset value of every output is 0. Reset during an in-flight transaction abandons it; any later bus response is ignored.
- Capture: a strobe sampled high on a port with no pending request latches addr, plus wdata, wmask and we for the data port, and sets that port's pend flag.
  - A strobe on an already pending port is ignored.
  - mem_i_rstrb held high permanently is legal; it re-requests on the cycle after completion.
  - mem_d_rstrb and mem_d_wstrb high together: treated as a write.
- Busy outputs:
  - mem_i_rbusy = i_pend.
  - mem_d_rbusy = d_pend & ~d_we.
  - mem_d_wbusy = d_pend & d_we.
  - Busy is low in the strobe cycle and high from the next cycle until completion.
- State machine:
  - IDLE: if any pend, select the winner (see Arbitration). Register bus_addr/wdata/wmask, pulse bus_rstrb or bus_wstrb next cycle, go to ISSUE.
  - ISSUE: the strobe is high for exactly this cycle; go to WAIT.
  - WAIT: when the relevant bus busy (rbusy for reads, wbusy for writes) is sampled low, the transaction completes.
    - On a read, the granted port's rdata is loaded from bus_rdata.
    - The granted port's pend is cleared and the state returns to IDLE.
    - A busy held high stalls indefinitely.
- Arbitration:
  - A single pending port wins.
  - Both pending: the port not granted last wins. The pointer updates on every grant.
  - Sustained contention strictly alternates grants.
- Latency with a zero-wait bus (strobe at cycle T):
  - pend high at T+1.
  - Bus strobe at T+2.
  - Completion sampled at the end of T+3.
  - rdata valid and busy low at T+4.
- rdata holds its value until the next completed read on that port.
- Capture in the same cycle as completion of the other port is allowed.
- A new strobe on the completing port in its completion cycle is ignored (still pending). It is accepted one cycle later.
- Bus strobes are never asserted outside ISSUE. bus_addr/wdata/wmask stay stable from ISSUE through completion.

Decomposition:
- Shared package/header: state encodings (ARB_IDLE, ARB_ISSUE, ARB_WAIT) and port IDs (ARB_PORT_I=0, ARB_PORT_D=1).
- One sub-module: rr_arb2. Inputs are two requests, the last-grant pointer and an update enable. Outputs are a one-hot grant and the next pointer.

Test Plan:
- Isolated instruction read:
  - Stimulus: mem_i_addr=0x10, pulse rstrb at T; bus returns 0xDEADBEEF with zero wait.
  - Response: bus_rstrb pulse at T+2 with bus_addr=0x10; mem_i_rdata=0xDEADBEEF and rbusy low at T+4.
- Data store with wait states:
  - Stimulus: addr=0x104, wdata=0x11223344, wmask=4'b0010; bus_wbusy held high for 3 cycles.
  - Response: single bus_wstrb with matching addr, data and mask; mem_d_wbusy high until the cycle after wbusy falls; no read-data change.
- Simultaneous requests:
  - Stimulus: I and D strobe in the same cycle after reset (FIRST_D=1).
  - Response: I granted first, then D; each rdata matches the bus data returned for its own address.
- Contention fairness:
  - Stimulus: i_rstrb tied high; D issues 4 back-to-back loads.
  - Response: bus grants alternate I,D,I,D,I,D,I,D; no port waits more than one foreign transaction.
- Illegal and edge strobes:
  - Stimulus: rstrb+wstrb together on D.
  - Response: a write is issued.
  - Stimulus: a strobe on an already pending port.
  - Response: no second bus transaction.
- Reset mid-WAIT:
  - Stimulus: assert rst while bus_rbusy is high, then release.
  - Response: all busies and strobes are 0 the cycle after reset; a later bus completion does not update rdata.
